kernel_launch_ctrl: RTL



---
 rtl/kernel_launch_ctrl.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/kernel_launch_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : kernel_launch_ctrl                                              |
// | Purpose  : Programs an OpenCL kernel CRA slave over Avalon-MM. It writes   |
// |            the argument words and then the start register, and waits for   |
// |            kernel_irq while counting cycles, with an optional timeout.     |
// | Revision : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
// | Build option:                                                              |
// |   KLC_SPLIT_HALF_EN defined  : each argument is written twice to the same  |
// |                                address (byteenable 0F, then F0)            |
// |   KLC_SPLIT_HALF_EN undefined: one write per argument, byteenable FF       |
// +----------------------------------------------------------------------------+
// | Ports:                                                                     |
// |   clk, rst          kernel clock, asynchronous active-high reset           |
// |   start_i           launch request, sampled in IDLE only                   |
// |   args_i            ARG_CNT x 64-bit argument words (arg i at [64i+:64])   |
// |   timeout_limit_i   max wait cycles, 0 disables the timeout                |
// |   busy_o            high from accepted start until DONE exits              |
// |   done_o            one-cycle completion pulse                             |
// |   timeout_o         wait ended by timeout, held until next start           |
// |   cycles_o          wait-cycle count, held until next start                |
// |   cra_*             Avalon-MM write master toward the kernel CRA slave     |
// |   kernel_irq        kernel completion interrupt (level)                    |
// +----------------------------------------------------------------------------+
module kernel_launch_ctrl #(
  parameter int ARG_CNT       = 11,
  parameter int CRA_ADDR_W    = 8,
  parameter int ARG_BASE_ADDR = 5,
  parameter int START_ADDR    = 0,
  parameter int GAP_CYCLES    = 2,
  parameter int CNT_W         = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_i,
  input  logic [ARG_CNT*64-1:0]   args_i,
  input  logic [CNT_W-1:0]        timeout_limit_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    timeout_o,
  output logic [CNT_W-1:0]        cycles_o,
  output logic [CRA_ADDR_W-1:0]   cra_address,
  output logic                    cra_write,
  output logic [63:0]             cra_writedata,
  output logic [7:0]              cra_byteenable,
  input  logic                    cra_waitrequest,
  input  logic                    kernel_irq
);

`ifdef KLC_SPLIT_HALF_EN
  localparam int N_WR = 2*ARG_CNT + 1;
  localparam logic [7:0] C_BE_FIRST = 8'h0F;
`else
  localparam int N_WR = ARG_CNT + 1;
  localparam logic [7:0] C_BE_FIRST = 8'hFF;
`endif

  localparam int IDX_W = $clog2(N_WR + 1);
  localparam int AIX_W = (ARG_CNT > 1) ? $clog2(ARG_CNT) : 1;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [IDX_W-1:0]      C_LAST_IDX   = IDX_W'(N_WR - 1);
  localparam logic [IDX_W-1:0]      C_ARG_CNT    = IDX_W'(ARG_CNT);
  localparam logic [IDX_W-1:0]      C_IDX_ONE    = IDX_W'(1);
  localparam logic [GAP_W-1:0]      C_GAP_LOAD   = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [GAP_W-1:0]      C_GAP_ONE    = GAP_W'(1);
  localparam logic [CNT_W-1:0]      C_CNT_ONE    = CNT_W'(1);
  localparam logic [CRA_ADDR_W-1:0] C_ARG_BASE   = CRA_ADDR_W'(ARG_BASE_ADDR);
  localparam logic [CRA_ADDR_W-1:0] C_START_ADDR = CRA_ADDR_W'(START_ADDR);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WR       = 3'd1,
    ST_GAP      = 3'd2,
    ST_WAIT_IRQ = 3'd3,
    ST_DONE     = 3'd4
  } state_t;

  state_t           state_q;
  logic [IDX_W-1:0] widx_q;
  logic [GAP_W-1:0] gap_q;
  logic [CNT_W-1:0] limit_q;
  logic [63:0]      args_q [ARG_CNT];

  // Fields of the write that is loaded next. From WR the next write is
  // widx+1 (index bumps on acceptance); from GAP the index was already bumped.
  logic [IDX_W-1:0]      nidx_d;
  logic [IDX_W-1:0]      arg_full_d;
  logic [AIX_W-1:0]      arg_idx_d;
  logic [CRA_ADDR_W-1:0] addr_d;
  logic [63:0]           data_d;
  logic [7:0]            be_d;

  always_comb begin
    nidx_d = (state_q == ST_GAP) ? widx_q : widx_q + C_IDX_ONE;
`ifdef KLC_SPLIT_HALF_EN
    arg_full_d = nidx_d >> 1;
    be_d       = nidx_d[0] ? 8'hF0 : 8'h0F;
`else
    arg_full_d = nidx_d;
    be_d       = 8'hFF;
`endif
    // Clamp so the start-write slot never indexes past the argument array.
    arg_idx_d = (arg_full_d < C_ARG_CNT) ? arg_full_d[AIX_W-1:0] : '0;
    if (nidx_d == C_LAST_IDX) begin
      addr_d = C_START_ADDR;
      data_d = 64'h1;
      be_d   = 8'h0F;
    end else begin
      addr_d = C_ARG_BASE + CRA_ADDR_W'(arg_idx_d);
      data_d = args_q[arg_idx_d];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      widx_q         <= '0;
      gap_q          <= '0;
      limit_q        <= '0;
      for (int i = 0; i < ARG_CNT; i++) args_q[i] <= '0;
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
      timeout_o      <= 1'b0;
      cycles_o       <= '0;
      cra_address    <= '0;
      cra_write      <= 1'b0;
      cra_writedata  <= '0;
      cra_byteenable <= '0;
    end else begin
      done_o <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            for (int i = 0; i < ARG_CNT; i++) args_q[i] <= args_i[64*i +: 64];
            limit_q        <= timeout_limit_i;
            cycles_o       <= '0;
            timeout_o      <= 1'b0;
            widx_q         <= '0;
            busy_o         <= 1'b1;
            // First write comes straight from the input bus, since the
            // argument registers are only being loaded on this edge.
            cra_write      <= 1'b1;
            cra_address    <= C_ARG_BASE;
            cra_writedata  <= args_i[63:0];
            cra_byteenable <= C_BE_FIRST;
            state_q        <= ST_WR;
          end
        end

        ST_WR: begin
          if (!cra_waitrequest) begin
            if (widx_q == C_LAST_IDX) begin
              cra_write <= 1'b0;
              state_q   <= ST_WAIT_IRQ;
            end else begin
              widx_q <= widx_q + C_IDX_ONE;
              if (GAP_CYCLES == 0) begin
                cra_address    <= addr_d;
                cra_writedata  <= data_d;
                cra_byteenable <= be_d;
              end else begin
                cra_write <= 1'b0;
                gap_q     <= C_GAP_LOAD;
                state_q   <= ST_GAP;
              end
            end
          end
        end

        ST_GAP: begin
          if (gap_q == '0) begin
            cra_write      <= 1'b1;
            cra_address    <= addr_d;
            cra_writedata  <= data_d;
            cra_byteenable <= be_d;
            state_q        <= ST_WR;
          end else begin
            gap_q <= gap_q - C_GAP_ONE;
          end
        end

        ST_WAIT_IRQ: begin
          cycles_o <= (cycles_o == '1) ? cycles_o : cycles_o + C_CNT_ONE;
          // irq has priority over a timeout landing on the same cycle.
          if (kernel_irq) begin
            done_o  <= 1'b1;
            state_q <= ST_DONE;
          end else if ((limit_q != '0) && (cycles_o + C_CNT_ONE == limit_q)) begin
            done_o    <= 1'b1;
            timeout_o <= 1'b1;
            state_q   <= ST_DONE;
          end
        end

        ST_DONE: begin
          busy_o  <= 1'b0;
          state_q <= ST_IDLE;
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
